// File: rtl/external_clk_if.sv
// Enable inputs and clock/reset outputs between the
// clock generator and the CPU core it feeds.
interface external_clk_if;
    logic CLK_ENA;
    logic OSC_ENA;
    logic OSC_STABLE;
    logic ASYNC_RESET;
    logic SYNC_RESET;
    logic MAIN_CLK_P;
    logic MAIN_CLK_N;
    logic ADR_CLK_P;
    logic ADR_CLK_N;
    logic DATA_CLK_P;
    logic DATA_CLK_N;
    logic INC_CLK_P;
    logic INC_CLK_N;
    logic LATCH_CLK;

    modport master (
        output CLK_ENA, OSC_ENA,
        input  OSC_STABLE, ASYNC_RESET, SYNC_RESET,
        input  MAIN_CLK_P, MAIN_CLK_N,
        input  ADR_CLK_P, ADR_CLK_N,
        input  DATA_CLK_P, DATA_CLK_N,
        input  INC_CLK_P, INC_CLK_N,
        input  LATCH_CLK
    );

    modport slave (
        input  CLK_ENA, OSC_ENA,
        output OSC_STABLE, ASYNC_RESET, SYNC_RESET,
        output MAIN_CLK_P, MAIN_CLK_N,
        output ADR_CLK_P, ADR_CLK_N,
        output DATA_CLK_P, DATA_CLK_N,
        output INC_CLK_P, INC_CLK_N,
        output LATCH_CLK
    );
endinterface

// File: rtl/external_clk.sv
// 8-phase machine-cycle sequencer producing complementary core
// clock pairs, oscillator-stable detection and core resets.
module external_clk #(
    parameter int STABLE_CYCLES = 16
) (
    input logic           CLK,
    input logic           RESET,
    external_clk_if.slave bus
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [CW-1:0] stab_cnt;
    logic [CW-1:0] stab_nxt;
    logic          stable_q;
    logic          stable_nxt;
    logic          run;
    logic [2:0]    ph;
    logic [2:0]    ph_nxt;
    logic          ar_m;
    logic          ar_q;
    logic          sr;
    logic          sr_nxt;
    // {main, adr, inc, data, latch}
    logic [4:0]    clk_q;
    logic [4:0]    clk_nxt;

    always_comb begin
        stab_nxt = stab_cnt;
        if (!bus.OSC_ENA)
            stab_nxt = '0;
        else if (stab_cnt != CW'(STABLE_CYCLES))
            stab_nxt = stab_cnt + 1'b1;
        stable_nxt = bus.OSC_ENA &&
                     (stab_nxt == CW'(STABLE_CYCLES));

        run    = bus.CLK_ENA & stable_q;
        ph_nxt = run ? ph + 3'd1 : ph;

        clk_nxt = 5'b00000;
        if (run) begin
            unique case (ph_nxt)
                3'd0: clk_nxt = 5'b10000;
                3'd1: clk_nxt = 5'b11000;
                3'd2: clk_nxt = 5'b11100;
                3'd3: clk_nxt = 5'b11100;
                3'd4: clk_nxt = 5'b01110;
                3'd5: clk_nxt = 5'b00110;
                3'd6: clk_nxt = 5'b00010;
                3'd7: clk_nxt = 5'b00001;
            endcase
        end

        // Set wins over the wrap release on the same edge.
        sr_nxt = sr;
        if (ar_m || !stable_nxt)
            sr_nxt = 1'b1;
        else if (run && ph == 3'd7)
            sr_nxt = 1'b0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ar_m     <= 1'b1;
            ar_q     <= 1'b1;
            stab_cnt <= '0;
            stable_q <= 1'b0;
            ph       <= 3'd0;
            clk_q    <= 5'b00000;
            sr       <= 1'b1;
        end else begin
            ar_m     <= 1'b0;
            ar_q     <= ar_m;
            stab_cnt <= stab_nxt;
            stable_q <= stable_nxt;
            ph       <= ph_nxt;
            clk_q    <= clk_nxt;
            sr       <= sr_nxt;
        end
    end

    assign bus.OSC_STABLE  = stable_q;
    assign bus.ASYNC_RESET = ar_q;
    assign bus.SYNC_RESET  = sr;

    // Each N is the inverse of the same flop as its P.
    assign bus.MAIN_CLK_P  = clk_q[4];
    assign bus.MAIN_CLK_N  = ~clk_q[4];
    assign bus.ADR_CLK_P   = clk_q[3];
    assign bus.ADR_CLK_N   = ~clk_q[3];
    assign bus.INC_CLK_P   = clk_q[2];
    assign bus.INC_CLK_N   = ~clk_q[2];
    assign bus.DATA_CLK_P  = clk_q[1];
    assign bus.DATA_CLK_N  = ~clk_q[1];
    assign bus.LATCH_CLK   = clk_q[0];

endmodule

// File: tb/tb_external_clk.sv
// Scoreboard bench for external_clk: stimulus queues expected
// per-edge states, a negedge monitor pops and compares them.
module tb_external_clk;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    external_clk_if bus();

    external_clk #(.STABLE_CYCLES(16)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] st;
        logic [4:0] ck;
        logic       ck_en;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;
    int ph = 0;

    function automatic logic [4:0] dec(input int p);
        return {p <= 3,
                p >= 1 && p <= 4,
                p >= 2 && p <= 5,
                p >= 4 && p <= 6,
                p == 7};
    endfunction

    task automatic chk(input string name,
                       input logic [7:0] act,
                       input logic [7:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h want %h at %0t",
                      name, act, req, $time);
    endtask

    always begin
        exp_t e;
        @(negedge CLK);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("status",
                {5'b0, bus.OSC_STABLE, bus.ASYNC_RESET,
                 bus.SYNC_RESET},
                {5'b0, e.st});
            if (e.ck_en) begin
                chk("clocks",
                    {3'b0, bus.MAIN_CLK_P, bus.ADR_CLK_P,
                     bus.INC_CLK_P, bus.DATA_CLK_P,
                     bus.LATCH_CLK},
                    {3'b0, e.ck});
                chk("pairs_n",
                    {4'b0, bus.MAIN_CLK_N, bus.ADR_CLK_N,
                     bus.INC_CLK_N, bus.DATA_CLK_N},
                    {4'b0, ~e.ck[4:1]});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic s, input logic a,
                        input logic r, input logic running,
                        input logic en);
        exp_t e;
        e.st    = {s, a, r};
        e.ck    = running ? dec(ph) : 5'b00000;
        e.ck_en = en;
        q.push_back(e);
    endtask

    // Edge n after RESET release: ASYNC off after 2, stable
    // after 16, phases from 17, SYNC off at the first wrap (24).
    task automatic restart(input int n_edges);
        ph = 0;
        for (int n = 1; n <= n_edges; n++) begin
            tick();
            if (n > 16) ph = (ph + 1) % 8;
            push(n >= 16, n < 2, n < 24, n > 16, 1'b1);
        end
    endtask

    task automatic step_run();
        tick();
        ph = (ph + 1) % 8;
        push(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        logic sr_e;
        bus.CLK_ENA = 1'b1;
        bus.OSC_ENA = 1'b1;
        #2 RESET = 1'b0;
        repeat (20) begin
            tick();
            push(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        end
        RESET = 1'b1;
        restart(40);

        repeat (1000) step_run();

        // One-edge oscillator dropout.
        bus.OSC_ENA = 1'b0;
        tick();
        ph = (ph + 1) % 8;
        push(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        bus.OSC_ENA = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            push(k == 16, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        sr_e = 1'b1;
        repeat (24) begin
            tick();
            if (ph == 7) sr_e = 1'b0;
            ph = (ph + 1) % 8;
            push(1'b1, 1'b0, sr_e, 1'b1, 1'b1);
        end

        // Freeze at phase 3, resume at phase 4.
        while (ph != 3) step_run();
        bus.CLK_ENA = 1'b0;
        repeat (5) begin
            tick();
            push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        bus.CLK_ENA = 1'b1;
        repeat (8) step_run();

        // Reset dropped inside phase 5, checked before any edge.
        while (ph != 4) step_run();
        tick();
        #1 RESET = 1'b0;
        push(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) begin
            tick();
            push(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        end
        RESET = 1'b1;
        restart(40);

        tick();
        @(negedge CLK);
        #1;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d left want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
